id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage pipelined CPU; sits directly upstream of the ALU controller and ALU.
- Captures decode-stage control (alu_op, funct, datapath selects), operands and register addresses each cycle, and presents them to EX.
- Contains the load-use hazard detector: freezes PC and IF/ID and inserts a bubble into EX when required.
- Supports branch flush, a downstream hold, and a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register-address width
CNT_W, 16, bubble-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_alu_op  in  3  ALU op class from main control
id_funct  in  6  instruction [5:0]
id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write  in  1 each  decode controls
id_uses_rt  in  1  instruction reads rt as source
id_rs_data, id_rt_data, id_imm_ext  in  DATA_W each  operands, sign-extended immediate
id_rs, id_rt, id_rd  in  REG_AW each  register addresses
flush  in  1  squash instruction in ID (taken branch/jump)
ex_hold  in  1  freeze whole front end (downstream wait)
ex_valid  out  1  EX holds a real instruction
ex_alu_op  out  3  to ALU controller alu_op
ex_funct  out  6  to ALU controller funct
ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  out  1 each  registered controls
ex_rs_data, ex_rt_data, ex_imm_ext  out  DATA_W each  registered operands
ex_rs, ex_rt, ex_rd  out  REG_AW each  registered addresses
stall_front  out  1  combinational: hold PC and IF/ID this cycle
bubble_cnt  out  CNT_W  count of inserted bubbles, saturating

Behaviour:
- Reset (async, rst=1): every registered output 0, including ex_valid and bubble_cnt. stall_front evaluates from zeroed registers, so 0 unless ex_hold=1.
- load_use (combinational) = id_valid & ~flush & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- stall_front = ex_hold | load_use. Combinational, no registered delay.
- Per-edge update priority, highest first:
  - ex_hold=1: all registers keep their value; bubble_cnt unchanged.
  - flush=1: load bubble.
  - load_use=1: load bubble and increment bubble_cnt.
  - Otherwise: load all id_* into ex_*, with ex_valid <= id_valid.
- Bubble: all ex_* outputs 0, including data and addresses. ex_alu_op=000 yields a harmless ALU add; reg_write and mem_write are 0, so there are no architectural side effects.
- Flush-inserted bubbles are not counted; only load-use bubbles increment bubble_cnt.
- bubble_cnt saturates at all-ones; no wrap.
- Latency: exactly 1 cycle from ID to EX when there is no hold, flush or load_use.
- A load-use stall lasts exactly one cycle: after the bubble, ex_mem_read=0, so load_use drops and the held ID instruction advances on the next edge.
- Simultaneous events:
  - ex_hold with flush or load_use: hold wins. Flush must be re-presented by its source after the hold releases.
  - flush with load_use: load_use is masked by flush; stall_front = ex_hold only.
- rst asserted mid-stall or mid-hold: immediate clear; no residual stall after release.
- Register 0 never creates a hazard.

Test Plan:
- Normal flow: id_alu_op=010, id_funct=100010, id_rs_data=5, id_rt_data=3, id_reg_write=1, no hazards -> next cycle ex_alu_op=010, ex_funct=100010, ex_rs_data=5, ex_reg_write=1, ex_valid=1; stall_front=0.
- Load-use on rs: EX holds lw with ex_rt=8, ex_mem_read=1; ID has id_rs=8 -> stall_front=1 that cycle; next edge EX all zeros, bubble_cnt=1; following edge the ID instruction enters EX, stall_front=0.
- rt hazard gating: ex_rt=9 load, id_rt=9, id_rs=4. id_uses_rt=0 -> no stall. id_uses_rt=1 -> stall. Repeat with ex_rt=0 -> no stall.
- Flush vs load-use: load-use condition true and flush=1 same cycle -> stall_front=0, EX gets bubble, bubble_cnt unchanged.
- Hold: ex_hold=1 for 3 cycles with changing id_* inputs -> ex_* constant, stall_front=1 throughout; first edge after release loads the current id_* values.
- Reset and saturation: preset bubble_cnt near 16'hFFFF via repeated load-use, confirm it sticks at FFFF; assert rst asynchronously mid-cycle -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush, downstream hold
// and a saturating bubble counter.
// Latency: 1 cycle ID->EX; stall_front is combinational (same cycle).
// Backpressure: ex_hold freezes every register; stall_front tells PC and IF/ID to hold.
//
// Ports:
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   id_*              : decode-stage controls, operands and register addresses
//   flush             : squash the instruction in ID (taken branch/jump)
//   ex_hold           : downstream wait, freezes the whole front end
//   ex_*              : registered copy of the ID bundle presented to EX
//   stall_front       : hold PC and IF/ID this cycle (ex_hold | load_use)
//   bubble_cnt        : number of load-use bubbles inserted, saturating
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [2:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_reg_dst,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [2:0]        ex_alu_op,
  output logic [5:0]        ex_funct,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              stall_front,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [2:0]        alu_op;
    logic [5:0]        funct;
    logic              reg_dst;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } ex_bundle_t;

  ex_bundle_t          ex_q, ex_d, id_bundle;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                load_use;
  logic                rt_dep;
  logic                cnt_full;

  always_comb begin
    id_bundle            = '0;
    id_bundle.valid      = id_valid;
    id_bundle.alu_op     = id_alu_op;
    id_bundle.funct      = id_funct;
    id_bundle.reg_dst    = id_reg_dst;
    id_bundle.alu_src    = id_alu_src;
    id_bundle.mem_read   = id_mem_read;
    id_bundle.mem_write  = id_mem_write;
    id_bundle.mem_to_reg = id_mem_to_reg;
    id_bundle.reg_write  = id_reg_write;
    id_bundle.rs_data    = id_rs_data;
    id_bundle.rt_data    = id_rt_data;
    id_bundle.imm_ext    = id_imm_ext;
    id_bundle.rs         = id_rs;
    id_bundle.rt         = id_rt;
    id_bundle.rd         = id_rd;
  end

  // A load in EX whose destination is read by the instruction in ID. r0 is hard-wired,
  // so it never carries a dependency; a flushed ID instruction needs no stall.
  assign rt_dep   = id_uses_rt & (ex_q.rt == id_rt);
  assign load_use = id_valid & ~flush & ex_q.valid & ex_q.mem_read &
                    (ex_q.rt != '0) & ((ex_q.rt == id_rs) | rt_dep);

  assign stall_front = ex_hold | load_use;
  assign cnt_full    = (cnt_q == {CNT_W{1'b1}});

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (ex_hold) begin
      ex_d  = ex_q;
    end else if (flush) begin
      ex_d  = '0;
    end else if (load_use) begin
      // All-zero bubble: alu_op 000 is a harmless add, no register or memory write.
      ex_d  = '0;
      cnt_d = cnt_full ? cnt_q : cnt_q + 1'b1;
    end else begin
      ex_d  = id_bundle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_funct      = ex_q.funct;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_imm_ext    = ex_q.imm_ext;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write;
  logic        id_uses_rt;
  logic [31:0] id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush, ex_hold;
  logic        ex_valid;
  logic [2:0]  ex_alu_op;
  logic [5:0]  ex_funct;
  logic        ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        stall_front;
  logic [CW-1:0] bubble_cnt;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .ex_hold(ex_hold), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_funct(ex_funct), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall_front(stall_front), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [5:0]  funct;
    logic        reg_dst, alu_src, mr, mw, m2r, rw;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
  } instr_t;

  typedef struct {
    instr_t i;
    logic   uses, flush, hold;
  } in_t;

  typedef struct {
    in_t         i;
    logic        e_stall, e_valid;
    logic [2:0]  e_op;
    logic [5:0]  e_funct;
    logic [31:0] e_rsd;
    logic        e_mr;
    logic [4:0]  e_rt;
    logic        e_rw;
    int          e_cnt;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: what EX should hold, and the bubble count as a plain integer.
  instr_t m_ex;
  int     m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic valid, input logic [2:0] op, input logic [5:0] funct,
                             input logic [31:0] rsd, input logic [4:0] rs, input logic [4:0] rt,
                             input logic mr, input logic rw, input logic uses,
                             input logic fl, input logic hd);
    in_t r;
    r.i.valid = valid; r.i.op = op; r.i.funct = funct;
    r.i.rsd = rsd; r.i.rtd = rsd + 32'd1; r.i.imm = ~rsd;
    r.i.rs = rs; r.i.rt = rt; r.i.rd = rt + 5'd1;
    r.i.reg_dst = rw; r.i.alu_src = mr; r.i.mr = mr; r.i.mw = 1'b0; r.i.m2r = mr; r.i.rw = rw;
    r.uses = uses; r.flush = fl; r.hold = hd;
    return r;
  endfunction

  function automatic vec_t v(input in_t i, input logic st, input logic ev, input logic [2:0] eop,
                             input logic [5:0] ef, input logic [31:0] ersd, input logic emr,
                             input logic [4:0] ert, input logic erw, input int ecnt);
    vec_t r;
    r.i = i; r.e_stall = st; r.e_valid = ev; r.e_op = eop; r.e_funct = ef; r.e_rsd = ersd;
    r.e_mr = emr; r.e_rt = ert; r.e_rw = erw; r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic apply(input in_t x);
    id_valid = x.i.valid; id_alu_op = x.i.op; id_funct = x.i.funct;
    id_reg_dst = x.i.reg_dst; id_alu_src = x.i.alu_src; id_mem_read = x.i.mr;
    id_mem_write = x.i.mw; id_mem_to_reg = x.i.m2r; id_reg_write = x.i.rw;
    id_rs_data = x.i.rsd; id_rt_data = x.i.rtd; id_imm_ext = x.i.imm;
    id_rs = x.i.rs; id_rt = x.i.rt; id_rd = x.i.rd;
    id_uses_rt = x.uses; flush = x.flush; ex_hold = x.hold;
  endtask

  function automatic logic model_hazard(input in_t x);
    if (!x.i.valid || x.flush) return 1'b0;
    if (!m_ex.valid || !m_ex.mr || m_ex.rt == 5'd0) return 1'b0;
    return (m_ex.rt == x.i.rs) || (x.uses && m_ex.rt == x.i.rt);
  endfunction

  task automatic model_clear();
    m_ex = '{default: '0};
    m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(ex_valid), 64'(m_ex.valid));
    chk({tag, ".alu_op"}, 64'(ex_alu_op), 64'(m_ex.op));
    chk({tag, ".funct"}, 64'(ex_funct), 64'(m_ex.funct));
    chk({tag, ".ctrl"}, 64'({ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write}),
        64'({m_ex.reg_dst, m_ex.alu_src, m_ex.mr, m_ex.mw, m_ex.m2r, m_ex.rw}));
    chk({tag, ".rs_data"}, 64'(ex_rs_data), 64'(m_ex.rsd));
    chk({tag, ".rt_data"}, 64'(ex_rt_data), 64'(m_ex.rtd));
    chk({tag, ".imm"}, 64'(ex_imm_ext), 64'(m_ex.imm));
    chk({tag, ".regs"}, 64'({ex_rs, ex_rt, ex_rd}), 64'({m_ex.rs, m_ex.rt, m_ex.rd}));
    chk({tag, ".cnt"}, 64'(bubble_cnt), 64'(m_cnt));
  endtask

  // One model-checked cycle: drive at negedge, check stall, clock, check registers.
  task automatic step(input in_t x, input string tag);
    logic hz;
    @(negedge clk);
    apply(x);
    #1;
    hz = model_hazard(x);
    chk({tag, ".stall"}, 64'(stall_front), 64'(x.hold | hz));
    @(posedge clk);
    if (!x.hold) begin
      if (x.flush) m_ex = '{default: '0};
      else if (hz) begin
        m_ex = '{default: '0};
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end else m_ex = x.i;
    end
    #1;
    check_all(tag);
  endtask

  function automatic logic [4:0] pick_reg();
    logic [31:0] r;
    r = $urandom;
    case (r[1:0])
      2'd0: return 5'd0;
      2'd1: return 5'd8;
      2'd2: return 5'd9;
      default: return r[8:4];
    endcase
  endfunction

  function automatic in_t rand_in();
    in_t x;
    logic [31:0] r;
    r = $urandom;
    x = mk(r[2:0] != 3'd0, r[5:3], r[11:6], $urandom, pick_reg(), pick_reg(),
           r[13:12] == 2'd0, r[14], r[15], r[18:16] == 3'd0, r[21:19] == 3'd0);
    x.i.mw = r[22];
    x.i.reg_dst = r[23];
    return x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  vec_t tbl[$];
  in_t  lw8, use8;

  initial begin
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_clear();
    #2;
    check_all("reset");
    chk("reset.stall", 64'(stall_front), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    lw8  = mk(1, 3'd0, 6'h00, 32'd100, 5'd1, 5'd8, 1, 1, 0, 0, 0);
    use8 = mk(1, 3'd2, 6'h20, 32'd7, 5'd8, 5'd2, 0, 1, 1, 0, 0);

    tbl.push_back(v(mk(1, 3'd2, 6'h22, 32'd5, 5'd1, 5'd2, 0, 1, 1, 0, 0), 0, 1, 3'd2, 6'h22, 32'd5, 0, 5'd2, 1, 0));
    tbl.push_back(v(lw8, 0, 1, 3'd0, 6'h00, 32'd100, 1, 5'd8, 1, 0));
    tbl.push_back(v(use8, 1, 0, 3'd0, 6'h00, 32'd0, 0, 5'd0, 0, 1));
    tbl.push_back(v(use8, 0, 1, 3'd2, 6'h20, 32'd7, 0, 5'd2, 1, 1));
    tbl.push_back(v(mk(1, 3'd0, 6'h00, 32'd50, 5'd1, 5'd9, 1, 1, 0, 0, 0), 0, 1, 3'd0, 6'h00, 32'd50, 1, 5'd9, 1, 1));
    tbl.push_back(v(mk(1, 3'd2, 6'h20, 32'd11, 5'd4, 5'd9, 0, 1, 0, 0, 0), 0, 1, 3'd2, 6'h20, 32'd11, 0, 5'd9, 1, 1));
    tbl.push_back(v(mk(1, 3'd0, 6'h00, 32'd50, 5'd1, 5'd9, 1, 1, 0, 0, 0), 0, 1, 3'd0, 6'h00, 32'd50, 1, 5'd9, 1, 1));
    tbl.push_back(v(mk(1, 3'd2, 6'h20, 32'd11, 5'd4, 5'd9, 0, 1, 1, 0, 0), 1, 0, 3'd0, 6'h00, 32'd0, 0, 5'd0, 0, 2));
    tbl.push_back(v(mk(1, 3'd0, 6'h00, 32'd50, 5'd1, 5'd0, 1, 1, 0, 0, 0), 0, 1, 3'd0, 6'h00, 32'd50, 1, 5'd0, 1, 2));
    tbl.push_back(v(mk(1, 3'd2, 6'h20, 32'd11, 5'd0, 5'd0, 0, 1, 1, 0, 0), 0, 1, 3'd2, 6'h20, 32'd11, 0, 5'd0, 1, 2));
    tbl.push_back(v(lw8, 0, 1, 3'd0, 6'h00, 32'd100, 1, 5'd8, 1, 2));
    tbl.push_back(v(mk(1, 3'd2, 6'h20, 32'd7, 5'd8, 5'd2, 0, 1, 1, 1, 0), 0, 0, 3'd0, 6'h00, 32'd0, 0, 5'd0, 0, 2));
    tbl.push_back(v(mk(1, 3'd2, 6'h22, 32'd5, 5'd1, 5'd2, 0, 1, 1, 0, 0), 0, 1, 3'd2, 6'h22, 32'd5, 0, 5'd2, 1, 2));
    tbl.push_back(v(mk(1, 3'd3, 6'h01, 32'd111, 5'd3, 5'd4, 1, 0, 1, 0, 1), 1, 1, 3'd2, 6'h22, 32'd5, 0, 5'd2, 1, 2));
    tbl.push_back(v(mk(1, 3'd4, 6'h02, 32'd222, 5'd5, 5'd6, 0, 1, 0, 1, 1), 1, 1, 3'd2, 6'h22, 32'd5, 0, 5'd2, 1, 2));
    tbl.push_back(v(mk(0, 3'd5, 6'h03, 32'd333, 5'd7, 5'd7, 1, 1, 1, 0, 1), 1, 1, 3'd2, 6'h22, 32'd5, 0, 5'd2, 1, 2));
    tbl.push_back(v(mk(1, 3'd6, 6'h25, 32'd444, 5'd3, 5'd5, 0, 0, 1, 0, 0), 0, 1, 3'd6, 6'h25, 32'd444, 0, 5'd5, 0, 2));
    tbl.push_back(v(lw8, 0, 1, 3'd0, 6'h00, 32'd100, 1, 5'd8, 1, 2));
    tbl.push_back(v(mk(1, 3'd2, 6'h20, 32'd7, 5'd8, 5'd2, 0, 1, 1, 0, 1), 1, 1, 3'd0, 6'h00, 32'd100, 1, 5'd8, 1, 2));
    tbl.push_back(v(use8, 1, 0, 3'd0, 6'h00, 32'd0, 0, 5'd0, 0, 3));
    tbl.push_back(v(lw8, 0, 1, 3'd0, 6'h00, 32'd100, 1, 5'd8, 1, 3));
    tbl.push_back(v(mk(0, 3'd2, 6'h20, 32'd77, 5'd8, 5'd2, 0, 1, 1, 0, 0), 0, 0, 3'd2, 6'h20, 32'd77, 0, 5'd2, 1, 3));

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      apply(tbl[k].i);
      #1;
      chk($sformatf("tbl%0d.stall", k), 64'(stall_front), 64'(tbl[k].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.valid", k), 64'(ex_valid), 64'(tbl[k].e_valid));
      chk($sformatf("tbl%0d.alu_op", k), 64'(ex_alu_op), 64'(tbl[k].e_op));
      chk($sformatf("tbl%0d.funct", k), 64'(ex_funct), 64'(tbl[k].e_funct));
      chk($sformatf("tbl%0d.rs_data", k), 64'(ex_rs_data), 64'(tbl[k].e_rsd));
      chk($sformatf("tbl%0d.mem_read", k), 64'(ex_mem_read), 64'(tbl[k].e_mr));
      chk($sformatf("tbl%0d.rt", k), 64'(ex_rt), 64'(tbl[k].e_rt));
      chk($sformatf("tbl%0d.reg_write", k), 64'(ex_reg_write), 64'(tbl[k].e_rw));
      chk($sformatf("tbl%0d.cnt", k), 64'(bubble_cnt), 64'(tbl[k].e_cnt));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 400; k++) step(rand_in(), "rnd");

    // Drive the counter into saturation with back-to-back load-use pairs.
    for (int k = 0; k < CMAX + 6; k++) begin
      step(lw8, "sat_lw");
      step(use8, "sat_use");
    end
    chk("cnt_saturated", 64'(bubble_cnt), 64'(CMAX));

    // Asynchronous reset in the middle of a load-use stall.
    step(lw8, "ar_lw");
    @(negedge clk);
    apply(use8);
    #1;
    chk("ar.stall_before", 64'(stall_front), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    model_clear();
    check_all("ar_async");
    chk("ar.stall_in_reset", 64'(stall_front), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar.stall_after", 64'(stall_front), 64'd0);
    step(use8, "ar_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
